pipeline_sequencer: RTL and testbench

Multi-cycle stage sequencer for the AVR-subset CPU. It sits directly upstream of `signal_generation_unit` and produces the `pipeline_stage` and `cycle_count` values that unit decodes into control signals. It steps every instruction through IF → ID → EX → MEM → WB and holds MEM for a second cycle on instructions that move a 16-bit PC through the stack. It also supports a stall and keeps a retired-instruction counter.

---
 rtl/pipeline_sequencer_pkg.sv | 35 +++
 rtl/pipeline_sequencer_instr_counter.sv | 26 ++
 rtl/pipeline_sequencer.sv | 101 ++++++++++
 tb/tb_pipeline_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// pipeline_sequencer_pkg
//   Shared encodings for the AVR-subset CPU control path (the package form of
//   defines.vh): stage codes, opcode-type codes and the field widths used by
//   pipeline_sequencer and signal_generation_unit.
//   Helper: is_two_cycle_mem() flags the types whose MEM stage moves a
//   16-bit PC through the stack and therefore needs a second MEM cycle.
package pipeline_sequencer_pkg;

  // Field widths
  localparam int STAGE_COUNT  = 3;
  localparam int OPCODE_COUNT = 5;
  localparam int GROUP_COUNT  = 4;

  // Stage codes
  localparam logic [STAGE_COUNT-1:0] STAGE_IF  = 3'd0;
  localparam logic [STAGE_COUNT-1:0] STAGE_ID  = 3'd1;
  localparam logic [STAGE_COUNT-1:0] STAGE_EX  = 3'd2;
  localparam logic [STAGE_COUNT-1:0] STAGE_MEM = 3'd3;
  localparam logic [STAGE_COUNT-1:0] STAGE_WB  = 3'd4;

  // Opcode type codes
  localparam logic [OPCODE_COUNT-1:0] TYPE_NOP   = 5'd0;
  localparam logic [OPCODE_COUNT-1:0] TYPE_MOV   = 5'd1;
  localparam logic [OPCODE_COUNT-1:0] TYPE_ADD   = 5'd2;
  localparam logic [OPCODE_COUNT-1:0] TYPE_LD    = 5'd3;
  localparam logic [OPCODE_COUNT-1:0] TYPE_ST    = 5'd4;
  localparam logic [OPCODE_COUNT-1:0] TYPE_RJMP  = 5'd5;
  localparam logic [OPCODE_COUNT-1:0] TYPE_RCALL = 5'd6;
  localparam logic [OPCODE_COUNT-1:0] TYPE_RET   = 5'd7;

  function automatic logic is_two_cycle_mem(input logic [OPCODE_COUNT-1:0] op);
    return (op == TYPE_RET) || (op == TYPE_RCALL);
  endfunction

endpackage

// File: rtl/pipeline_sequencer_instr_counter.sv
// instr_counter
//   Wrapping retired-instruction counter (all-ones rolls to 0, no saturation).
//   Ports:
//     clk     - rising-edge clock
//     reset   - synchronous active-high reset, clears the count
//     i_en    - increment enable (one pulse per retired instruction)
//     o_count - current count, CNT_WIDTH bits
module instr_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_en,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset)     r_count <= '0;
    else if (i_en) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
//   Steps each instruction through IF -> ID -> EX -> MEM -> WB and back to IF.
//   RET/RCALL hold MEM for a second cycle (cycle_count 0 then 1). Supports a
//   level-sensitive stall and counts retired instructions.
//   Configuration: define SEQUENCER_STALL_EN to honour `stall`; otherwise the
//   port is present but ignored and instr_done fires in every WB cycle.
//   Ports:
//     clk            - rising-edge clock
//     reset          - synchronous active-high reset
//     stall          - freeze request from memory/IO wait logic
//     opcode_type    - decoded instruction type (sampled in MEM cycle 0)
//     opcode_group   - decoded group flags (carried, not used for sequencing)
//     pipeline_stage - current stage code
//     cycle_count    - sub-cycle index within the stage
//     instr_done     - pulse in the final non-stalled WB cycle
//     instr_retired  - count of completed instructions
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [OPCODE_COUNT-1:0] opcode_type,
  input  logic [GROUP_COUNT-1:0]  opcode_group,
  output logic [STAGE_COUNT-1:0]  pipeline_stage,
  output logic                    cycle_count,
  output logic                    instr_done,
  output logic [CNT_WIDTH-1:0]    instr_retired
);

  logic [STAGE_COUNT-1:0] r_stage, w_stage_n;
  logic                   r_cyc,   w_cyc_n;
  logic                   w_stall;

`ifdef SEQUENCER_STALL_EN
  assign w_stall = stall;
  logic w_unused_ok;
  assign w_unused_ok = ^opcode_group;
`else
  assign w_stall = 1'b0;
  logic w_unused_ok;
  assign w_unused_ok = ^{opcode_group, stall};
`endif

  always_comb begin
    w_stage_n = r_stage;
    w_cyc_n   = r_cyc;
    if (!w_stall) begin
      case (r_stage)
        STAGE_IF: w_stage_n = STAGE_ID;
        STAGE_ID: w_stage_n = STAGE_EX;
        STAGE_EX: begin
          w_stage_n = STAGE_MEM;
          w_cyc_n   = 1'b0;
        end
        STAGE_MEM: begin
          // Only MEM cycle 0 looks at the opcode; from cycle 1 the exit to
          // WB is already committed.
          if (!r_cyc && is_two_cycle_mem(opcode_type)) begin
            w_cyc_n = 1'b1;
          end else begin
            w_stage_n = STAGE_WB;
            w_cyc_n   = 1'b0;
          end
        end
        STAGE_WB: begin
          w_stage_n = STAGE_IF;
          w_cyc_n   = 1'b0;
        end
        default: begin
          w_stage_n = STAGE_IF;
          w_cyc_n   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage <= STAGE_IF;
      r_cyc   <= 1'b0;
    end else begin
      r_stage <= w_stage_n;
      r_cyc   <= w_cyc_n;
    end
  end

  assign pipeline_stage = r_stage;
  assign cycle_count    = r_cyc;
  assign instr_done     = (r_stage == STAGE_WB) && !w_stall;

  instr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_instr_counter (
    .clk     (clk),
    .reset   (reset),
    .i_en    (instr_done),
    .o_count (instr_retired)
  );

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;
  import pipeline_sequencer_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    stall;
  logic [OPCODE_COUNT-1:0] opcode_type;
  logic [GROUP_COUNT-1:0]  opcode_group;
  logic [STAGE_COUNT-1:0]  pipeline_stage;
  logic                    cycle_count;
  logic                    instr_done;
  logic [15:0]             instr_retired;

  // narrow-counter instance for the wrap check
  logic                    stall_w;
  logic [OPCODE_COUNT-1:0] op_w;
  logic [STAGE_COUNT-1:0]  stage_w;
  logic                    cyc_w;
  logic                    done_w;
  logic [2:0]              ret_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_sequencer #(.CNT_WIDTH(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .opcode_type    (opcode_type),
    .opcode_group   (opcode_group),
    .pipeline_stage (pipeline_stage),
    .cycle_count    (cycle_count),
    .instr_done     (instr_done),
    .instr_retired  (instr_retired)
  );

  pipeline_sequencer #(.CNT_WIDTH(3)) dut_w (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall_w),
    .opcode_type    (op_w),
    .opcode_group   (4'h0),
    .pipeline_stage (stage_w),
    .cycle_count    (cyc_w),
    .instr_done     (done_w),
    .instr_retired  (ret_w)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Check the current cycle's outputs, then advance to the next negedge.
  task automatic exp_cyc(input string tag, input logic [STAGE_COUNT-1:0] st,
                         input logic cyc, input logic done);
    check({tag, ".stage"}, 32'(pipeline_stage), 32'(st));
    check({tag, ".cyc"},   32'(cycle_count),    32'(cyc));
    check({tag, ".done"},  32'(instr_done),     32'(done));
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; opcode_type = TYPE_MOV; opcode_group = 4'h0;
    stall_w = 1'b0; op_w = TYPE_MOV;
    repeat (2) @(negedge clk);
    check("rst.retired", 32'(instr_retired), 0);
    reset = 1'b0;

    // MOV: five single-cycle stages
    exp_cyc("mov.if",  STAGE_IF,  1'b0, 1'b0);
    exp_cyc("mov.id",  STAGE_ID,  1'b0, 1'b0);
    exp_cyc("mov.ex",  STAGE_EX,  1'b0, 1'b0);
    exp_cyc("mov.mem", STAGE_MEM, 1'b0, 1'b0);
    exp_cyc("mov.wb",  STAGE_WB,  1'b0, 1'b1);
    check("mov.retired", 32'(instr_retired), 1);

    // RET: two MEM cycles; opcode change in MEM cycle 1 is ignored
    opcode_type = TYPE_RET;
    exp_cyc("ret.if",   STAGE_IF,  1'b0, 1'b0);
    exp_cyc("ret.id",   STAGE_ID,  1'b0, 1'b0);
    exp_cyc("ret.ex",   STAGE_EX,  1'b0, 1'b0);
    exp_cyc("ret.mem0", STAGE_MEM, 1'b0, 1'b0);
    opcode_type = TYPE_MOV;
    exp_cyc("ret.mem1", STAGE_MEM, 1'b1, 1'b0);
    exp_cyc("ret.wb",   STAGE_WB,  1'b0, 1'b1);
    check("ret.retired", 32'(instr_retired), 2);

    // RCALL with stall for 3 cycles from MEM cycle 0
    opcode_type = TYPE_RCALL;
    exp_cyc("rc.if", STAGE_IF, 1'b0, 1'b0);
    exp_cyc("rc.id", STAGE_ID, 1'b0, 1'b0);
    exp_cyc("rc.ex", STAGE_EX, 1'b0, 1'b0);
    stall = 1'b1;
`ifdef SEQUENCER_STALL_EN
    exp_cyc("rc.mem0a", STAGE_MEM, 1'b0, 1'b0);
    exp_cyc("rc.mem0b", STAGE_MEM, 1'b0, 1'b0);
    exp_cyc("rc.mem0c", STAGE_MEM, 1'b0, 1'b0);
    stall = 1'b0;
    exp_cyc("rc.mem0d", STAGE_MEM, 1'b0, 1'b0);
    exp_cyc("rc.mem1",  STAGE_MEM, 1'b1, 1'b0);
    exp_cyc("rc.wb",    STAGE_WB,  1'b0, 1'b1);
`else
    exp_cyc("rc.mem0", STAGE_MEM, 1'b0, 1'b0);
    exp_cyc("rc.mem1", STAGE_MEM, 1'b1, 1'b0);
    exp_cyc("rc.wb",   STAGE_WB,  1'b0, 1'b1);
    stall = 1'b0;
`endif
    check("rc.retired", 32'(instr_retired), 3);

    // Stall in WB for 2 cycles
    opcode_type = TYPE_MOV;
    exp_cyc("wbs.if",  STAGE_IF,  1'b0, 1'b0);
    exp_cyc("wbs.id",  STAGE_ID,  1'b0, 1'b0);
    exp_cyc("wbs.ex",  STAGE_EX,  1'b0, 1'b0);
    exp_cyc("wbs.mem", STAGE_MEM, 1'b0, 1'b0);
    stall = 1'b1;
`ifdef SEQUENCER_STALL_EN
    exp_cyc("wbs.wb0", STAGE_WB, 1'b0, 1'b0);
    check("wbs.hold", 32'(instr_retired), 3);
    exp_cyc("wbs.wb1", STAGE_WB, 1'b0, 1'b0);
    stall = 1'b0;
    exp_cyc("wbs.wb2", STAGE_WB, 1'b0, 1'b1);
`else
    exp_cyc("wbs.wb", STAGE_WB, 1'b0, 1'b1);
    stall = 1'b0;
`endif
    check("wbs.retired", 32'(instr_retired), 4);

    // Reset in EX while stalled
    exp_cyc("rx.if", STAGE_IF, 1'b0, 1'b0);
    exp_cyc("rx.id", STAGE_ID, 1'b0, 1'b0);
    check("rx.ex", 32'(pipeline_stage), 32'(STAGE_EX));
    reset = 1'b1; stall = 1'b1;
    @(negedge clk);
    check("rx.stage",   32'(pipeline_stage), 32'(STAGE_IF));
    check("rx.cyc",     32'(cycle_count),    0);
    check("rx.done",    32'(instr_done),     0);
    check("rx.retired", 32'(instr_retired),  0);
    check("rxw.retired", 32'(ret_w),         0);
    reset = 1'b0; stall = 1'b0;

    // Wrap on the 3-bit counter instance: 7 retires, then one more rolls to 0
    repeat (35) @(negedge clk);
    check("wrap.seven", 32'(ret_w),   7);
    check("wrap.stage", 32'(stage_w), 32'(STAGE_IF));
    repeat (4) @(negedge clk);
    check("wrap.wb",   32'(stage_w), 32'(STAGE_WB));
    check("wrap.done", 32'(done_w),  1);
    @(negedge clk);
    check("wrap.zero", 32'(ret_w), 0);
    check("wrap.cyc",  32'(cyc_w), 0);
    // main instance ran the same MOV stream after reset
    check("main.retired", 32'(instr_retired), 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
